// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle MIPS main FSM and its datapath.
// The FSM side uses the master modport; the datapath side uses slave.
interface multicycle_control_fsm_if;
  logic [5:0] Opcode;
  logic       jumpReg;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic [1:0] PCSource;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [3:0] State;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  Opcode, jumpReg, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, State,
           instr_done, illegal_op
  );

  modport slave (
    output Opcode, jumpReg, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, State,
           instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle MIPS datapath: fetch, decode, execute,
// memory and write-back sequencing with Moore outputs plus mem_ready gating.
module multicycle_control_fsm (
  input logic                     clk,
  input logic                     reset_n,
  multicycle_control_fsm_if.master bus
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] FETCH    = 4'd1;
  localparam logic [3:0] DECODE   = 4'd2;
  localparam logic [3:0] MEMADR   = 4'd3;
  localparam logic [3:0] MEMRD    = 4'd4;
  localparam logic [3:0] MEMWB    = 4'd5;
  localparam logic [3:0] MEMWR    = 4'd6;
  localparam logic [3:0] RTYPE_EX = 4'd7;
  localparam logic [3:0] RTYPE_WB = 4'd8;
  localparam logic [3:0] BEQ      = 4'd9;
  localparam logic [3:0] JUMP     = 4'd10;
  localparam logic [3:0] ADDI_EX  = 4'd11;
  localparam logic [3:0] ANDI_EX  = 4'd12;
  localparam logic [3:0] IMM_WB   = 4'd13;
  localparam logic [3:0] JR       = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  logic [3:0] state;
  logic [3:0] nextState;
  logic       opLegal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    opLegal = 1'b1;
    case (bus.Opcode)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_LW, OP_SW: opLegal = 1'b1;
      default:                                                 opLegal = 1'b0;
    endcase
  end

  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE:     nextState = FETCH;
      FETCH:    nextState = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.Opcode)
          OP_RTYPE:      nextState = RTYPE_EX;
          OP_LW, OP_SW:  nextState = MEMADR;
          OP_BEQ:        nextState = BEQ;
          OP_J:          nextState = JUMP;
          OP_ADDI:       nextState = ADDI_EX;
          OP_ANDI:       nextState = ANDI_EX;
          default:       nextState = FETCH;
        endcase
      end
      // A stable IR only ever reaches here with lw or sw; anything else refetches.
      MEMADR: begin
        if (bus.Opcode == OP_LW)      nextState = MEMRD;
        else if (bus.Opcode == OP_SW) nextState = MEMWR;
        else                          nextState = FETCH;
      end
      MEMRD:    nextState = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:    nextState = bus.mem_ready ? FETCH : MEMWR;
      RTYPE_EX: nextState = bus.jumpReg ? JR : RTYPE_WB;
      ADDI_EX, ANDI_EX: nextState = IMM_WB;
      MEMWB, RTYPE_WB, IMM_WB, BEQ, JUMP, JR: nextState = FETCH;
      default:  nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.PCSource    = 2'd0;
    bus.ALUSrcB     = 2'd0;
    bus.ALUOp       = 2'd0;
    bus.instr_done  = 1'b0;
    bus.illegal_op  = 1'b0;
    bus.State       = state;
    case (state)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'd1;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      DECODE: begin
        bus.ALUSrcB    = 2'd3;
        bus.illegal_op = ~opLegal;
        bus.instr_done = ~opLegal;
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'd2;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEMWB: begin
        bus.RegWrite   = 1'b1;
        bus.MemtoReg   = 1'b1;
        bus.instr_done = 1'b1;
      end
      MEMWR: begin
        bus.MemWrite   = 1'b1;
        bus.IorD       = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      RTYPE_EX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'd2;
      end
      RTYPE_WB: begin
        bus.RegWrite   = 1'b1;
        bus.RegDst     = 1'b1;
        bus.instr_done = 1'b1;
      end
      BEQ: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'd1;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'd1;
        bus.instr_done  = 1'b1;
      end
      JUMP: begin
        bus.PCWrite    = 1'b1;
        bus.PCSource   = 2'd2;
        bus.instr_done = 1'b1;
      end
      ADDI_EX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'd2;
      end
      ANDI_EX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'd2;
        bus.ALUOp   = 2'd3;
      end
      IMM_WB: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      JR: begin
        bus.PCWrite    = 1'b1;
        bus.PCSource   = 2'd3;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Table-driven bench for multicycle_control_fsm: per-cycle expectations are
// queued as stimulus is driven and popped when outputs are sampled.
module tb_multicycle_control_fsm;

  typedef struct {
    logic [5:0] op;
    logic       jr;
    logic       mr;
    logic [3:0] st;
    logic [9:0] fl;
    logic [1:0] pcs;
    logic [1:0] srcb;
    logic [1:0] aop;
    logic       done;
    logic       ill;
  } vec_t;

  // Flag order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg ALUSrcA RegWrite RegDst
  localparam logic [9:0] F_NONE  = 10'b0000000000;
  localparam logic [9:0] F_FET1  = 10'b1001010000;
  localparam logic [9:0] F_FET0  = 10'b0001000000;
  localparam logic [9:0] F_SRCA  = 10'b0000000100;
  localparam logic [9:0] F_MEMRD = 10'b0011000000;
  localparam logic [9:0] F_MEMWB = 10'b0000001010;
  localparam logic [9:0] F_MEMWR = 10'b0010100000;
  localparam logic [9:0] F_RWB   = 10'b0000000011;
  localparam logic [9:0] F_BEQ   = 10'b0100000100;
  localparam logic [9:0] F_PCW   = 10'b1000000000;
  localparam logic [9:0] F_IMMWB = 10'b0000000010;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  vec_t tbl[$];
  vec_t sb[$];

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [5:0] op, input logic jr, input logic mr, input logic [3:0] st,
                     input logic [9:0] fl, input logic [1:0] pcs, input logic [1:0] srcb,
                     input logic [1:0] aop, input logic done, input logic ill);
    vec_t v;
    v.op = op; v.jr = jr; v.mr = mr; v.st = st; v.fl = fl;
    v.pcs = pcs; v.srcb = srcb; v.aop = aop; v.done = done; v.ill = ill;
    tbl.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.Opcode    = v.op;
    bus.jumpReg   = v.jr;
    bus.mem_ready = v.mr;
    sb.push_back(v);
  endtask

  task automatic checkOutput(input string name, input int idx);
    vec_t        e;
    logic [17:0] want;
    logic [17:0] got;
    #1;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s[%0d] scoreboard: got empty queue, want one entry", name, idx);
    end else begin
      e    = sb.pop_front();
      want = {e.fl, e.pcs, e.srcb, e.aop, e.done, e.ill};
      got  = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
              bus.IRWrite, bus.MemtoReg, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
              bus.PCSource, bus.ALUSrcB, bus.ALUOp, bus.instr_done, bus.illegal_op};
      if (bus.State !== e.st) begin
        bad++;
        $display("FAIL %s[%0d] state: got %0d want %0d", name, idx, bus.State, e.st);
      end
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s[%0d] controls (state %0d): got %b want %b", name, idx, e.st, got, want);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, want finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t z;
    total = 0;
    bad   = 0;
    reset_n       = 1'b0;
    bus.Opcode    = 6'd0;
    bus.jumpReg   = 1'b0;
    bus.mem_ready = 1'b1;

    // R-type, lw with two wait cycles, sw, jr
    add(0,0,1, 1,F_FET1,0,1,0,0,0); add(0,0,1, 2,F_NONE,0,3,0,0,0);
    add(0,0,1, 7,F_SRCA,0,0,2,0,0); add(0,0,1, 8,F_RWB,0,0,0,1,0);
    add(35,0,1,1,F_FET1,0,1,0,0,0); add(35,0,1,2,F_NONE,0,3,0,0,0);
    add(35,0,1,3,F_SRCA,0,2,0,0,0); add(35,0,0,4,F_MEMRD,0,0,0,0,0);
    add(35,0,0,4,F_MEMRD,0,0,0,0,0); add(35,0,1,4,F_MEMRD,0,0,0,0,0);
    add(35,0,1,5,F_MEMWB,0,0,0,1,0);
    add(43,0,1,1,F_FET1,0,1,0,0,0); add(43,0,1,2,F_NONE,0,3,0,0,0);
    add(43,0,1,3,F_SRCA,0,2,0,0,0); add(43,0,1,6,F_MEMWR,0,0,0,1,0);
    add(0,0,1, 1,F_FET1,0,1,0,0,0); add(0,0,1, 2,F_NONE,0,3,0,0,0);
    add(0,1,1, 7,F_SRCA,0,0,2,0,0); add(0,1,1,14,F_PCW,3,0,0,1,0);
    // beq, j, andi, addi with a fetch wait (jumpReg toggled where it must be ignored), illegal
    add(4,1,1, 1,F_FET1,0,1,0,0,0); add(4,1,1, 2,F_NONE,0,3,0,0,0);
    add(4,1,1, 9,F_BEQ,1,0,1,1,0);
    add(2,0,1, 1,F_FET1,0,1,0,0,0); add(2,0,1, 2,F_NONE,0,3,0,0,0);
    add(2,0,1,10,F_PCW,2,0,0,1,0);
    add(12,0,1,1,F_FET1,0,1,0,0,0); add(12,0,1,2,F_NONE,0,3,0,0,0);
    add(12,1,1,12,F_SRCA,0,2,3,0,0); add(12,0,1,13,F_IMMWB,0,0,0,1,0);
    add(8,0,0, 1,F_FET0,0,1,0,0,0); add(8,0,1, 1,F_FET1,0,1,0,0,0);
    add(8,1,1, 2,F_NONE,0,3,0,0,0); add(8,1,0,11,F_SRCA,0,2,0,0,0);
    add(8,0,1,13,F_IMMWB,0,0,0,1,0);
    add(63,0,1,1,F_FET1,0,1,0,0,0); add(63,1,1,2,F_NONE,0,3,0,1,1);
    add(43,0,1,1,F_FET1,0,1,0,0,0); add(43,0,1,2,F_NONE,0,3,0,0,0);
    add(43,0,1,3,F_SRCA,0,2,0,0,0); add(43,0,0,6,F_MEMWR,0,0,0,0,0);

    z.op = 6'd0; z.jr = 1'b0; z.mr = 1'b1; z.st = 4'd0; z.fl = F_NONE;
    z.pcs = 2'd0; z.srcb = 2'd0; z.aop = 2'd0; z.done = 1'b0; z.ill = 1'b0;

    repeat (2) @(negedge clk);
    applyStimulus(z);
    checkOutput("reset", 0);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      applyStimulus(tbl[i]);
      checkOutput("vec", i);
    end

    // Abort a stalled sw mid-cycle, then confirm restart through IDLE into FETCH
    #1;
    reset_n = 1'b0;
    z.op = 6'd43; z.mr = 1'b0;
    applyStimulus(z);
    checkOutput("abort", 0);
    @(negedge clk);
    applyStimulus(z);
    checkOutput("abort", 1);
    reset_n = 1'b1;
    @(negedge clk);
    z.mr = 1'b1; z.st = 4'd1; z.fl = F_FET1; z.srcb = 2'd1;
    applyStimulus(z);
    checkOutput("recover", 0);
    @(negedge clk);
    z.st = 4'd2; z.fl = F_NONE; z.srcb = 2'd3;
    applyStimulus(z);
    checkOutput("recover", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
